// File: rtl/gf_mul_arbiter_if.sv
// gf_mul_arbiter_if: request/response bundle for the shared GF(2^8) multiplier
interface gf_mul_arbiter_if #(
    parameter int M     = 8,
    parameter int N_REQ = 4
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*M-1:0] req_a;
    logic [N_REQ*M-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [M-1:0]       rsp_prod;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_ready;
    logic               busy;
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_prod, rsp_id, busy
    );
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_prod, rsp_id, busy
    );
endinterface

// File: rtl/gf_mul_arbiter.sv
// gf_mul_arbiter: round-robin arbiter feeding one shared 2-stage GF(2^8) multiplier pipeline
module gf_mul_arbiter #(
    parameter int M     = 8,
    parameter int N_REQ = 4
) (
    input logic          clk,
    input logic          rst_n,
    gf_mul_arbiter_if.slave bus
);
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int POLY = 'h11D;

    logic [IDW-1:0]   ptr, win, s1_id, s2_id;
    logic [M-1:0]     s1_a, s1_b, s2_p, prod;
    logic [N_REQ-1:0] grant;
    logic             found, s1_v, s2_v, s1_load, s2_load;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p ^= x;
            x = x[M-1] ? ((x << 1) ^ POLY[M-1:0]) : (x << 1);
        end
        return p;
    endfunction

    assign s2_load = !s2_v || bus.rsp_ready;
    assign s1_load = !s1_v || s2_load;
    assign prod    = gf_mul(s1_a, s1_b);

    // round-robin search from ptr; no grant while S1 is stalled or reset is held
    always_comb begin
        logic [IDW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant = (found && s1_load && rst_n) ? N_REQ'(1) << win : '0;
    end

    // pointer moves just past the requester that was granted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (|grant) ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;

    // S1 captures the granted operands; an empty slot is loaded when nobody wins
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
        end else if (s1_load) begin
            s1_v  <= |grant;
            s1_a  <= bus.req_a[win*M +: M];
            s1_b  <= bus.req_b[win*M +: M];
            s1_id <= win;
        end

    // S2 captures the product and owner id; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s2_v  <= 1'b0;
            s2_p  <= '0;
            s2_id <= '0;
        end else if (s2_load) begin
            s2_v  <= s1_v;
            s2_p  <= prod;
            s2_id <= s1_id;
        end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = s2_v;
    assign bus.rsp_prod  = s2_p;
    assign bus.rsp_id    = s2_id;
    assign bus.busy      = s1_v || s2_v;
endmodule
